// File: rtl/adsr_envelope.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adsr_envelope                                                            |
// | Tick-paced ADSR amplitude generator with synchronized gate input.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module adsr_envelope #(
   parameter int CLKSPEED = 48_000_000,
   parameter int TICK_HZ  = 48_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       gate,
   input  logic [9:0] attack_rate,
   input  logic [9:0] decay_rate,
   input  logic [9:0] sustain_level,
   input  logic [9:0] release_rate,
   output logic [9:0] amp,
   output logic [2:0] stage,
   output logic       tick
);

   localparam int c_DIV = CLKSPEED / TICK_HZ;
   localparam int c_CW  = (c_DIV > 2) ? $clog2(c_DIV) : 1;
   localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_DIV - 1);
   localparam logic [c_CW-1:0] c_CNT_PRE  = c_CW'(c_DIV - 2);
   localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } state_t;

   state_t            r_state;
   logic [9:0]        r_amp;
   logic [c_CW-1:0]   r_cnt;
   logic              r_tick;
   logic              r_gate_m;
   logic              r_gate_s;
   logic              r_gate_d;
   logic [2:0]        r_settle;

   logic              w_rise;
   logic              w_fall;
   logic [10:0]       w_att_sum;
   logic signed [10:0] w_dec_diff;
   logic signed [10:0] w_sus_ext;
   logic              w_dec_hit;
   logic              w_rel_hit;
   logic [9:0]        w_rel_diff;

   // Edges are only trusted once the synchronizer holds real samples, so a
   // gate already high when reset is released does not fire a note.
   assign w_rise = r_settle[2] &  r_gate_s & ~r_gate_d;
   assign w_fall = r_settle[2] & ~r_gate_s &  r_gate_d;

   assign w_att_sum  = {1'b0, r_amp} + {1'b0, attack_rate};
   assign w_dec_diff = $signed({1'b0, r_amp}) - $signed({1'b0, decay_rate});
   assign w_sus_ext  = $signed({1'b0, sustain_level});
   assign w_dec_hit  = (w_dec_diff <= w_sus_ext);
   assign w_rel_hit  = (r_amp <= release_rate);
   assign w_rel_diff = r_amp - release_rate;

   assign amp   = r_amp;
   assign stage = r_state;
   assign tick  = r_tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gate_m <= 1'b0;
         r_gate_s <= 1'b0;
         r_gate_d <= 1'b0;
         r_settle <= 3'b000;
      end else begin
         r_gate_m <= gate;
         r_gate_s <= r_gate_m;
         r_gate_d <= r_gate_s;
         r_settle <= {r_settle[1:0], 1'b1};
      end
   end

   // Tick is registered one count early so it is high while the counter is at DIV-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + c_CNT_ONE;
         r_tick <= (r_cnt == c_CNT_PRE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_amp   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_amp <= '0;
               if (w_rise) r_state <= ST_ATTACK;
            end
            ST_ATTACK: begin
               if (w_fall) begin
                  r_state <= ST_RELEASE;
               end else if (r_tick) begin
                  if (w_att_sum >= 11'd1023) begin
                     r_amp   <= 10'd1023;
                     r_state <= ST_DECAY;
                  end else begin
                     r_amp <= w_att_sum[9:0];
                  end
               end
            end
            ST_DECAY: begin
               if (w_fall) begin
                  r_state <= ST_RELEASE;
               end else if (r_tick) begin
                  if (w_dec_hit) begin
                     r_amp   <= sustain_level;
                     r_state <= ST_SUSTAIN;
                  end else begin
                     r_amp <= w_dec_diff[9:0];
                  end
               end
            end
            ST_SUSTAIN: begin
               if (w_fall) r_state <= ST_RELEASE;
               else        r_amp   <= sustain_level;
            end
            ST_RELEASE: begin
               // Retrigger keeps the current amplitude to avoid a click.
               if (w_rise) begin
                  r_state <= ST_ATTACK;
               end else if (r_tick) begin
                  if (w_rel_hit) begin
                     r_amp   <= '0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_amp <= w_rel_diff;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_amp   <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adsr_envelope.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_adsr_envelope                                                         |
// | Directed self-checking bench for adsr_envelope at DIV = 10.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_adsr_envelope;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       gate;
   logic [9:0] attack_rate;
   logic [9:0] decay_rate;
   logic [9:0] sustain_level;
   logic [9:0] release_rate;
   logic [9:0] amp;
   logic [2:0] stage;
   logic       tick;

   int n_cmp = 0;
   int n_err = 0;

   adsr_envelope #(.CLKSPEED(100), .TICK_HZ(10)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .gate         (gate),
      .attack_rate  (attack_rate),
      .decay_rate   (decay_rate),
      .sustain_level(sustain_level),
      .release_rate (release_rate),
      .amp          (amp),
      .stage        (stage),
      .tick         (tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_stage(input logic [2:0] want, input string tag);
      for (int i = 0; i < 300 && stage !== want; i++) step();
      chk(tag, 32'(stage), 32'(want));
   endtask

   // Advance to the sample just after the next tick-driven update.
   task automatic next_update(input string tag);
      for (int i = 0; i < 20 && tick !== 1'b1; i++) step();
      chk({tag, "_tick"}, 32'(tick), 32'd1);
      step();
   endtask

   initial begin
      rst_n         = 1'b0;
      gate          = 1'b0;
      attack_rate   = 10'd256;
      decay_rate    = 10'd100;
      sustain_level = 10'd800;
      release_rate  = 10'd300;

      // Reset state and tick cadence
      #2;
      chk("rst_amp", 32'(amp), 32'd0);
      chk("rst_stage", 32'(stage), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      #20 rst_n = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         step();
         chk($sformatf("tick_k%0d", k), 32'(tick), (k % 10 == 9) ? 32'd1 : 32'd0);
      end

      // Full envelope: attack then decay into sustain
      gate = 1'b1;
      wait_stage(3'd1, "env_attack");
      chk("env_att_amp0", 32'(amp), 32'd0);
      next_update("a1"); chk("a1_amp", 32'(amp), 32'd256);
      next_update("a2"); chk("a2_amp", 32'(amp), 32'd512);
      next_update("a3"); chk("a3_amp", 32'(amp), 32'd768);
      next_update("a4"); chk("a4_amp", 32'(amp), 32'd1023);
      chk("a4_stage", 32'(stage), 32'd2);
      next_update("d1"); chk("d1_amp", 32'(amp), 32'd923);
      next_update("d2"); chk("d2_amp", 32'(amp), 32'd823);
      next_update("d3"); chk("d3_amp", 32'(amp), 32'd800);
      chk("d3_stage", 32'(stage), 32'd3);

      // Sustain follows the level every clock
      sustain_level = 10'd600;
      step();
      chk("sus_600", 32'(amp), 32'd600);
      sustain_level = 10'd800;
      step();
      chk("sus_800", 32'(amp), 32'd800);

      // Release down to idle
      gate = 1'b0;
      wait_stage(3'd4, "rel_enter");
      chk("rel_amp0", 32'(amp), 32'd800);
      next_update("r1"); chk("r1_amp", 32'(amp), 32'd500);
      next_update("r2"); chk("r2_amp", 32'(amp), 32'd200);
      next_update("r3"); chk("r3_amp", 32'(amp), 32'd0);
      chk("r3_stage", 32'(stage), 32'd0);

      // Retrigger during release keeps the amplitude
      gate = 1'b1;
      wait_stage(3'd3, "rt_sustain");
      chk("rt_sus_amp", 32'(amp), 32'd800);
      gate = 1'b0;
      wait_stage(3'd4, "rt_release");
      next_update("rt_r1"); chk("rt_r1_amp", 32'(amp), 32'd500);
      gate = 1'b1;
      wait_stage(3'd1, "rt_attack");
      chk("rt_att_amp", 32'(amp), 32'd500);
      next_update("rt_a1"); chk("rt_a1_amp", 32'(amp), 32'd756);

      // Falling edge coinciding with a tick: no release decrement that cycle
      wait_stage(3'd3, "coll_sustain");
      for (int i = 0; i < 20 && tick !== 1'b1; i++) step();
      repeat (8) step();
      gate = 1'b0;
      step();
      step();
      chk("coll_tick", 32'(tick), 32'd1);
      chk("coll_pre_stage", 32'(stage), 32'd3);
      step();
      chk("coll_stage", 32'(stage), 32'd4);
      chk("coll_amp", 32'(amp), 32'd800);
      next_update("coll_r1"); chk("coll_r1_amp", 32'(amp), 32'd500);
      next_update("coll_r2"); chk("coll_r2_amp", 32'(amp), 32'd200);
      next_update("coll_r3"); chk("coll_r3_stage", 32'(stage), 32'd0);

      // Zero attack rate holds the envelope in attack
      attack_rate = 10'd0;
      gate = 1'b1;
      wait_stage(3'd1, "zr_attack");
      for (int t = 0; t < 50; t++) begin
         next_update($sformatf("zr%0d", t));
         chk($sformatf("zr%0d_amp", t), 32'(amp), 32'd0);
      end
      chk("zr_stage", 32'(stage), 32'd1);
      gate = 1'b0;
      wait_stage(3'd4, "zr_release");
      next_update("zr_rel");
      chk("zr_idle", 32'(stage), 32'd0);
      chk("zr_idle_amp", 32'(amp), 32'd0);

      // Asynchronous reset in the middle of attack
      attack_rate = 10'd256;
      gate = 1'b1;
      wait_stage(3'd1, "ar_attack");
      next_update("ar1"); chk("ar1_amp", 32'(amp), 32'd256);
      next_update("ar2"); chk("ar2_amp", 32'(amp), 32'd512);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_amp", 32'(amp), 32'd0);
      chk("ar_stage", 32'(stage), 32'd0);
      #3 rst_n = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         step();
         chk($sformatf("ar_tick_k%0d", k), 32'(tick), (k % 10 == 9) ? 32'd1 : 32'd0);
      end
      chk("ar_hold_idle", 32'(stage), 32'd0);
      chk("ar_hold_amp", 32'(amp), 32'd0);

      // A genuine rising edge after reset still triggers
      gate = 1'b0;
      repeat (4) step();
      gate = 1'b1;
      wait_stage(3'd1, "ar_retrigger");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/adsr_envelope.md
ADSR_ENVELOPE -- requirements
Module: adsr_envelope

Interface
REQ-001 Parameter CLKSPEED, default 48_000_000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 48_000, envelope update rate in Hz; divisor DIV = CLKSPEED/TICK_HZ, always >= 2.
REQ-003 Port clk  input  1  single system clock; all state on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port gate  input  1  note gate, asynchronous to clk (button-derived).
REQ-006 Port attack_rate  input  10  amplitude increment per tick in ATTACK.
REQ-007 Port decay_rate  input  10  amplitude decrement per tick in DECAY.
REQ-008 Port sustain_level  input  10  SUSTAIN hold amplitude.
REQ-009 Port release_rate  input  10  amplitude decrement per tick in RELEASE.
REQ-010 Port amp  output  10  registered envelope amplitude, drives the synth amp_in.
REQ-011 Port stage  output  3  registered state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-012 Port tick  output  1  one-clock pulse on every envelope update tick.

Function
REQ-013 gate passes through a 2-flop synchronizer; gate_s is the second flop; rising/falling edges are detected against a third registered copy.
REQ-014 Tick counter counts 0..DIV-1 and wraps; tick is high in the cycle the counter equals DIV-1; the tick period is exactly DIV clocks.
REQ-015 Amplitude updates only on tick cycles, except the immediate transitions in REQ-020/REQ-021; all arithmetic is 11-bit with explicit saturation, no wrap.
REQ-016 IDLE: amp held at 0.
REQ-017 ATTACK: on tick, amp = min(amp + attack_rate, 1023); when the result is 1023, stage becomes DECAY in the same update.
REQ-018 DECAY: on tick, if amp - decay_rate <= sustain_level (signed compare), amp = sustain_level and stage becomes SUSTAIN; otherwise amp -= decay_rate.
REQ-019 SUSTAIN: amp follows sustain_level every clock (not tick-gated).
REQ-020 A gate_s rising edge in IDLE or RELEASE moves to ATTACK on the next clock; amp keeps its current value (retrigger without click).
REQ-021 A gate_s falling edge in ATTACK, DECAY or SUSTAIN moves to RELEASE on the next clock; amp keeps its current value.
REQ-022 RELEASE: on tick, if amp <= release_rate, amp = 0 and stage becomes IDLE; otherwise amp -= release_rate.
REQ-023 A rate of 0 holds amp in that stage indefinitely; this is legal and not an error.
REQ-024 When an edge and a tick occur in the same cycle, the edge transition wins and no tick arithmetic is applied.
REQ-025 If gate_s is high while in IDLE with no edge, for example after reset, the envelope stays in IDLE; only a rising edge triggers it.
REQ-026 Rate and level inputs are sampled on use; changes take effect on the next tick (next clock in SUSTAIN).

Reset
REQ-027 rst_n low asynchronously forces amp=0, stage=IDLE, tick=0, tick counter=0, and all synchronizer/edge flops=0.
REQ-028 Reset asserted mid-envelope aborts immediately; after release, operation resumes from IDLE at counter 0.

Verification
All scenarios use CLKSPEED=100 and TICK_HZ=10, so DIV=10.
REQ-029 Tick: after reset release, tick pulses every 10 clocks, each exactly 1 cycle wide.
REQ-030 Full envelope: attack=256, decay=100, sustain=800, release=300. Raise gate -> amp per tick is 256, 512, 768, 1023, then stage DECAY; then 923, 823, 800, then SUSTAIN. Drop gate -> RELEASE; amp 500, 200, 0, then IDLE.
REQ-031 Retrigger: drop gate during RELEASE at amp=500, then raise gate -> stage ATTACK with amp still 500; next tick amp=756.
REQ-032 Zero rate: attack=0 with gate high -> stage 1 held and amp stays 0 for 50 ticks; drop gate -> RELEASE, then IDLE on the first tick.
REQ-033 Sustain tracking and collision: in SUSTAIN, change sustain_level 800->600 -> amp=600 within 1 clock. Align a gate falling edge with a tick cycle -> RELEASE entered with no decrement in that cycle.
REQ-034 Async reset: assert rst_n low between clock edges during ATTACK at amp=512 -> amp=0 and stage=0 before the next edge. Gate held high through reset release -> remains IDLE (REQ-025).
